qs_rom_arbiter: RTL and testbench

Shares the single registered q-constant ROM (6-bit select, 59-bit word, one-cycle latency) between N_REQ datapath units, e.g. the CRT lifting unit and the modular-reduction unit. Each requester asks for a burst of 1–4 consecutive ROM words. The arbiter grants one requester at a time, sequences the ROM select, and returns the words tagged with requester ID and a last flag. It sits between the ROM and its consumers in the arithmetic core.

---
 rtl/qs_pkg.sv | 18 +
 rtl/qs_rom_arbiter_if.sv | 33 +++
 rtl/qs_arb_grant.sv | 63 ++++++
 rtl/qs_rom_arbiter.sv | 114 +++++++++++
 tb/tb_qs_rom_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/qs_pkg.sv
// rtl/qs_pkg.sv - shared constants, FSM state and response tag type for the q-constant ROM arbiter
package qs_pkg;
    localparam int QS_WORD_W    = 59;
    localparam int QS_SEL_W     = 6;
    localparam int QS_NUM_WORDS = 4;
    localparam int QS_ID_W      = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        logic               valid;
        logic [QS_ID_W-1:0] id;
        logic               last;
    } qs_tag_t;
endpackage

// File: rtl/qs_rom_arbiter_if.sv
// rtl/qs_rom_arbiter_if.sv - request, ROM and response bundle between the arbiter and its neighbours
interface qs_rom_arbiter_if
    import qs_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int WORD_W = QS_WORD_W,
    parameter int SEL_W  = QS_SEL_W,
    parameter int LEN_W  = $clog2(QS_NUM_WORDS)
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*SEL_W-1:0] req_base;
    logic [N_REQ*LEN_W-1:0] req_len;
    logic [SEL_W-1:0]       rom_sel;
    logic [WORD_W-1:0]      rom_word;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_last;
    logic [WORD_W-1:0]      rsp_word;
    logic                   busy;

    modport master (
        output req_valid, req_base, req_len, rom_word,
        input  req_ready, rom_sel, rsp_valid, rsp_id, rsp_last, rsp_word, busy
    );

    modport slave (
        input  req_valid, req_base, req_len, rom_word,
        output req_ready, rom_sel, rsp_valid, rsp_id, rsp_last, rsp_word, busy
    );
endinterface

// File: rtl/qs_arb_grant.sv
// rtl/qs_arb_grant.sv - one-hot winner selection; QS_ARB_ROUND_ROBIN_EN selects round-robin
// with a last-grant pointer, otherwise fixed priority with the lowest index winning.
module qs_arb_grant #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
`ifdef QS_ARB_ROUND_ROBIN_EN
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_hs,
`endif
    input  logic [N_REQ-1:0] i_req_valid,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_grant_id
);
    logic w_found;

`ifdef QS_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_ptr;

    // First pass covers indices above the last grant, second pass wraps to the rest.
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        w_found    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && i_req_valid[i] && (i > int'(r_ptr))) begin
                o_grant[i] = 1'b1;
                o_grant_id = ID_W'(i);
                w_found    = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && i_req_valid[i] && (i <= int'(r_ptr))) begin
                o_grant[i] = 1'b1;
                o_grant_id = ID_W'(i);
                w_found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= ID_W'(N_REQ - 1);
        end else if (i_hs) begin
            r_ptr <= o_grant_id;
        end
    end
`else
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        w_found    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && i_req_valid[i]) begin
                o_grant[i] = 1'b1;
                o_grant_id = ID_W'(i);
                w_found    = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/qs_rom_arbiter.sv
// rtl/qs_rom_arbiter.sv - shares the registered q-constant ROM between requesters issuing 1-4 word bursts;
// QS_ARB_ROUND_ROBIN_EN switches the grant policy from fixed priority to round-robin.
module qs_rom_arbiter
    import qs_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int WORD_W = QS_WORD_W,
    parameter int SEL_W  = QS_SEL_W,
    parameter int LEN_W  = $clog2(QS_NUM_WORDS)
) (
    input logic             clk,
    input logic             rst_n,
    qs_rom_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [SEL_W-1:0] r_base;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [ID_W-1:0]  r_id;
    qs_tag_t          r_tag;

    logic [N_REQ-1:0] w_grant;
    logic [N_REQ-1:0] w_ready;
    logic [ID_W-1:0]  w_grant_id;
    logic [SEL_W-1:0] w_req_base;
    logic [LEN_W-1:0] w_req_len;
    logic             w_hs;
    logic             w_issue_last;

    qs_arb_grant #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_grant (
`ifdef QS_ARB_ROUND_ROBIN_EN
        .clk         (clk),
        .rst_n       (rst_n),
        .i_hs        (w_hs),
`endif
        .i_req_valid (bus.req_valid),
        .o_grant     (w_grant),
        .o_grant_id  (w_grant_id)
    );

    always_comb begin
        w_req_base = '0;
        w_req_len  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_req_base = bus.req_base[i*SEL_W +: SEL_W];
                w_req_len  = bus.req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign w_issue_last = (r_state == ISSUE) && (r_cnt == r_len);

    // Ready is masked while reset is held so no requester sees an accept during reset.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_hs        = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = rst_n ? w_grant : '0;
                w_hs    = |(bus.req_valid & w_ready);
                if (w_hs) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_issue_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The tag stage runs alongside the ROM's one-cycle latency so tags line up with rom_word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_id    <= '0;
            r_tag   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_base <= w_req_base;
                r_len  <= w_req_len;
                r_id   <= w_grant_id;
                r_cnt  <= '0;
            end else if (r_state == ISSUE) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
            r_tag.valid <= (r_state == ISSUE);
            r_tag.id    <= QS_ID_W'(r_id);
            r_tag.last  <= w_issue_last;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rom_sel   = (r_state == ISSUE) ? (r_base + SEL_W'(r_cnt)) : '0;
    assign bus.rsp_valid = r_tag.valid;
    assign bus.rsp_id    = ID_W'(r_tag.id);
    assign bus.rsp_last  = r_tag.last;
    assign bus.rsp_word  = r_tag.valid ? bus.rom_word : '0;
    assign bus.busy      = (r_state == ISSUE) | r_tag.valid;
endmodule

// File: tb/tb_qs_rom_arbiter.sv
// tb/tb_qs_rom_arbiter.sv - randomized bench for qs_rom_arbiter against a transaction-level schedule model;
// honours QS_ARB_ROUND_ROBIN_EN for the expected grant policy.
module tb_qs_rom_arbiter;
    localparam int N    = 2;
    localparam int ID_W = $clog2(N);

    typedef struct {
        logic [ID_W-1:0] id;
        logic            last;
        logic [58:0]     word;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    qs_rom_arbiter_if #(.N_REQ(N)) bus ();

    qs_rom_arbiter #(.N_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [N-1:0] st_valid;
    logic [5:0]   st_base [N];
    logic [1:0]   st_len  [N];
    logic [N-1:0] rearm;
    bit           rnd_mode;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int free_cyc = 0;
    int rr_ptr   = N - 1;
    int win;
    int acc_cnt  [N];
    int drv_seen [N];
    int hs_cyc   [N];
    int gl [$];
    logic [5:0] exp_sel [int];
    exp_t       exp_rsp [int];
    logic [N-1:0] exp_ready;

    function automatic logic [58:0] rom_f(input logic [5:0] s);
        case (s)
            6'd0:    rom_f = 59'd393394748469346305;
            6'd1:    rom_f = 59'd417767552804925659;
            6'd2:    rom_f = 59'd506224710668493737;
            6'd3:    rom_f = 59'd7;
            default: rom_f = 59'd0;
        endcase
    endfunction

    always_comb begin
        bus.req_valid = st_valid;
        for (int i = 0; i < N; i++) begin
            bus.req_base[i*6 +: 6] = st_base[i];
            bus.req_len[i*2 +: 2]  = st_len[i];
        end
    end

    always @(posedge clk) bus.rom_word <= rom_f(bus.rom_sel);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check_eq("rst_req_ready", 64'(bus.req_ready), 0);
            check_eq("rst_rom_sel", 64'(bus.rom_sel), 0);
            check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 0);
            check_eq("rst_rsp_id", 64'(bus.rsp_id), 0);
            check_eq("rst_rsp_last", 64'(bus.rsp_last), 0);
            check_eq("rst_rsp_word", 64'(bus.rsp_word), 0);
            check_eq("rst_busy", 64'(bus.busy), 0);
            exp_sel.delete();
            exp_rsp.delete();
            free_cyc = cyc + 1;
            rr_ptr   = N - 1;
        end else begin
            win = -1;
            if (cyc >= free_cyc) begin
`ifdef QS_ARB_ROUND_ROBIN_EN
                for (int k = 1; k <= N; k++)
                    if (win < 0 && st_valid[(rr_ptr + k) % N]) win = (rr_ptr + k) % N;
`else
                for (int j = 0; j < N; j++)
                    if (win < 0 && st_valid[j]) win = j;
`endif
            end
            exp_ready = (win >= 0) ? (N'(1) << win) : '0;
            check_eq("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            check_eq("rom_sel", 64'(bus.rom_sel), exp_sel.exists(cyc) ? 64'(exp_sel[cyc]) : 64'd0);
            if (exp_rsp.exists(cyc)) begin
                check_eq("rsp_valid", 64'(bus.rsp_valid), 1);
                check_eq("rsp_id", 64'(bus.rsp_id), 64'(exp_rsp[cyc].id));
                check_eq("rsp_last", 64'(bus.rsp_last), 64'(exp_rsp[cyc].last));
                check_eq("rsp_word", 64'(bus.rsp_word), 64'(exp_rsp[cyc].word));
            end else begin
                check_eq("rsp_valid", 64'(bus.rsp_valid), 0);
                check_eq("rsp_word_idle", 64'(bus.rsp_word), 0);
            end
            check_eq("busy", 64'(bus.busy), 64'(exp_sel.exists(cyc) || exp_rsp.exists(cyc)));
            for (int i = 0; i < N; i++)
                if (bus.req_ready[i] && st_valid[i]) gl.push_back(i);
            exp_sel.delete(cyc);
            exp_rsp.delete(cyc);
            if (win >= 0) begin
                for (int k = 0; k <= int'(st_len[win]); k++) begin
                    exp_sel[cyc + 1 + k] = st_base[win] + 6'(k);
                    exp_rsp[cyc + 2 + k] = '{id: ID_W'(win), last: (k == int'(st_len[win])),
                                             word: rom_f(st_base[win] + 6'(k))};
                end
                free_cyc = cyc + int'(st_len[win]) + 2;
                rr_ptr   = win;
                acc_cnt[win]++;
                hs_cyc[win] = cyc;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_cnt[i] != drv_seen[i]) begin
                drv_seen[i] = acc_cnt[i];
                if (!rearm[i]) st_valid[i] = 1'b0;
            end
        end
        if (rnd_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!st_valid[i]) begin
                    if ($urandom % 3 == 0) begin
                        case ($urandom % 4)
                            0:       st_base[i] = 6'($urandom % 4);
                            1:       st_base[i] = 6'(62 + $urandom % 2);
                            default: st_base[i] = 6'($urandom % 64);
                        endcase
                        st_len[i]   = 2'($urandom % 4);
                        st_valid[i] = 1'b1;
                    end
                end else if ($urandom % 25 == 0) begin
                    st_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic req_wait(input int id, input logic [5:0] base, input logic [1:0] len, output int t);
        int n0;
        n0 = acc_cnt[id];
        st_base[id]  = base;
        st_len[id]   = len;
        st_valid[id] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (acc_cnt[id] != n0) break;
        end
        check_eq("accept_timeout", 64'(acc_cnt[id] != n0), 1);
        t = hs_cyc[id];
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (exp_sel.num() == 0 && exp_rsp.num() == 0) break;
            tick();
        end
        check_eq("drain_timeout", 64'(exp_sel.num() + exp_rsp.num()), 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int t1, t2;
    int exp_g [4];

    initial begin
        rst_n    = 1'b0;
        st_valid = '0;
        rearm    = '0;
        rnd_mode = 1'b0;
        for (int i = 0; i < N; i++) begin
            st_base[i]  = '0;
            st_len[i]   = '0;
            acc_cnt[i]  = 0;
            drv_seen[i] = 0;
            hs_cyc[i]   = 0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        req_wait(0, 6'd0, 2'd3, t1);
        drain();

        apply_reset();
        gl.delete();
        rearm = '1;
        for (int i = 0; i < N; i++) begin
            st_base[i]  = 6'd0;
            st_len[i]   = 2'd0;
            st_valid[i] = 1'b1;
        end
        repeat (12) tick();
        rearm    = '0;
        st_valid = '0;
        drain();
`ifdef QS_ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        check_eq("grant_count", 64'(gl.size() >= 4), 1);
        for (int k = 0; k < 4 && k < gl.size(); k++)
            check_eq("grant_order", 64'(gl[k]), 64'(exp_g[k]));

        req_wait(1, 6'd2, 2'd1, t1);
        drain();
        req_wait(0, 6'd63, 2'd1, t1);
        drain();

        req_wait(0, 6'd0, 2'd3, t1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_wait(1, 6'd2, 2'd1, t1);
        drain();

        req_wait(0, 6'd0, 2'd1, t1);
        req_wait(0, 6'd0, 2'd0, t2);
        check_eq("b2b_gap", 64'(t2 - t1), 3);
        drain();

        rnd_mode = 1'b1;
        repeat (2000) tick();
        rnd_mode = 1'b0;
        st_valid = '0;
        tick();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
